// File: rtl/ps2_scan_decoder_pkg.sv
// Shared constants and types for the PS/2 set-2 scan-code decoder.
package ps2_scan_decoder_pkg;

    // Set-2 prefix bytes
    localparam logic [7:0] SC_EXT = 8'hE0;
    localparam logic [7:0] SC_BRK = 8'hF0;

    // Prefix-interpreter states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXT  = 2'd1;
    localparam logic [1:0] ST_BRK  = 2'd2;

    // One queued key event, 10 bits: {ext, brk, code}
    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } key_event_t;

    localparam int KEY_EVENT_W = $bits(key_event_t);

endpackage

// File: rtl/ps2_scan_decoder_kb_fifo.sv
// Small register-array synchronous FIFO with first-word fall-through output.
// A write while full is dropped unless a pop happens in the same cycle;
// a pop while empty is ignored.
module kb_fifo #(
    parameter int DW = 10,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd,
    output logic [DW-1:0] dout,
    output logic          empty,
    output logic          full
);

    localparam int DEPTH = 2 ** AW;
    localparam logic [AW:0] DEPTH_CNT = DEPTH[AW:0];

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_rd;
    logic          do_wr;

    assign empty = (count == '0);
    assign full  = (count == DEPTH_CNT);
    assign dout  = mem[rd_ptr];

    // Qualify requests: pops need data, pushes need room (a same-cycle pop frees a slot)
    always_comb begin
        do_rd = rd & ~empty;
        do_wr = wr & (~full | do_rd);
    end

    // Storage array, cleared on reset so the head reads zero while empty
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally; occupancy tracks net pushes minus pops
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ps2_scan_decoder.sv
// Interprets the raw set-2 byte stream (E0 extend, F0 break prefixes) and
// queues completed key events for the game logic. By default only releases
// are queued, so typematic repeat never produces extra events.
module ps2_scan_decoder
    import ps2_scan_decoder_pkg::*;
#(
    parameter int FIFO_AW   = 2,
    parameter int PUSH_MAKE = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_done_tick,
    input  logic [7:0] rx_data,
    input  logic       rd_key,
    output logic [7:0] key_code,
    output logic       key_brk,
    output logic       key_ext,
    output logic       kb_empty,
    output logic       kb_full,
    output logic       overflow,
    output logic       proto_err
);

    localparam logic PUSH_MAKE_EN = (PUSH_MAKE != 0);

    logic [1:0] state;
    logic [1:0] state_next;
    logic       ext;
    logic       ext_next;
    logic       emit;
    logic       bad_prefix;
    key_event_t ev;
    key_event_t head;
    logic       drop_next;

    // Prefix interpreter: decides the next state and whether a byte completes an event
    always_comb begin
        state_next = state;
        ext_next   = ext;
        emit       = 1'b0;
        bad_prefix = 1'b0;
        ev         = '0;
        if (rx_done_tick) begin
            case (state)
                ST_IDLE: begin
                    if (rx_data == SC_EXT) begin
                        state_next = ST_EXT;
                    end else if (rx_data == SC_BRK) begin
                        state_next = ST_BRK;
                        ext_next   = 1'b0;
                    end else begin
                        emit = PUSH_MAKE_EN;
                        ev   = '{ext: 1'b0, brk: 1'b0, code: rx_data};
                    end
                end
                ST_EXT: begin
                    if (rx_data == SC_BRK) begin
                        state_next = ST_BRK;
                        ext_next   = 1'b1;
                    end else if (rx_data != SC_EXT) begin
                        emit       = PUSH_MAKE_EN;
                        ev         = '{ext: 1'b1, brk: 1'b0, code: rx_data};
                        state_next = ST_IDLE;
                        ext_next   = 1'b0;
                    end
                end
                ST_BRK: begin
                    if ((rx_data == SC_EXT) || (rx_data == SC_BRK)) begin
                        bad_prefix = 1'b1;
                    end else begin
                        emit = 1'b1;
                        ev   = '{ext: ext, brk: 1'b1, code: rx_data};
                    end
                    state_next = ST_IDLE;
                    ext_next   = 1'b0;
                end
                default: begin
                    state_next = ST_IDLE;
                    ext_next   = 1'b0;
                end
            endcase
        end
    end

    // An event is lost only when the FIFO is full and no pop frees a slot this cycle
    always_comb begin
        drop_next = emit & kb_full & ~(rd_key & ~kb_empty);
    end

    // State, ext flag and the one-cycle status pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            ext       <= 1'b0;
            overflow  <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            state     <= state_next;
            ext       <= ext_next;
            overflow  <= drop_next;
            proto_err <= bad_prefix;
        end
    end

    kb_fifo #(
        .DW (KEY_EVENT_W),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr      (emit),
        .wr_data (ev),
        .rd      (rd_key),
        .dout    (head),
        .empty   (kb_empty),
        .full    (kb_full)
    );

    assign key_code = head.code;
    assign key_brk  = head.brk;
    assign key_ext  = head.ext;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Directed bench for ps2_scan_decoder: a release-only instance (dut0) and a
// make-and-break instance (dut1) share one byte stream.
module tb_ps2_scan_decoder;

    logic       clk;
    logic       reset;
    logic       rx_done_tick;
    logic [7:0] rx_data;
    logic       rd_key;

    logic [7:0] key_code0, key_code1;
    logic       key_brk0, key_brk1;
    logic       key_ext0, key_ext1;
    logic       kb_empty0, kb_empty1;
    logic       kb_full0, kb_full1;
    logic       overflow0, overflow1;
    logic       proto_err0, proto_err1;

    int errors = 0;
    int checks = 0;

    ps2_scan_decoder #(.FIFO_AW(2), .PUSH_MAKE(0)) dut0 (
        .clk          (clk),
        .reset        (reset),
        .rx_done_tick (rx_done_tick),
        .rx_data      (rx_data),
        .rd_key       (rd_key),
        .key_code     (key_code0),
        .key_brk      (key_brk0),
        .key_ext      (key_ext0),
        .kb_empty     (kb_empty0),
        .kb_full      (kb_full0),
        .overflow     (overflow0),
        .proto_err    (proto_err0)
    );

    ps2_scan_decoder #(.FIFO_AW(2), .PUSH_MAKE(1)) dut1 (
        .clk          (clk),
        .reset        (reset),
        .rx_done_tick (rx_done_tick),
        .rx_data      (rx_data),
        .rd_key       (rd_key),
        .key_code     (key_code1),
        .key_brk      (key_brk1),
        .key_ext      (key_ext1),
        .kb_empty     (kb_empty1),
        .kb_full      (kb_full1),
        .overflow     (overflow1),
        .proto_err    (proto_err1)
    );

    // 100 MHz-style free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Present one byte for exactly one clock; returns at the following falling edge
    task automatic applyStimulus(input logic [7:0] b, input logic pop);
        @(negedge clk);
        rx_data      = b;
        rx_done_tick = 1'b1;
        rd_key       = pop;
        @(negedge clk);
        rx_done_tick = 1'b0;
        rd_key       = 1'b0;
    endtask

    task automatic popKey();
        @(negedge clk);
        rd_key = 1'b1;
        @(negedge clk);
        rd_key = 1'b0;
    endtask

    task automatic idleCycle();
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic logic [15:0] head0();
        return {6'b0, key_ext0, key_brk0, key_code0};
    endfunction

    function automatic logic [15:0] head1();
        return {6'b0, key_ext1, key_brk1, key_code1};
    endfunction

    initial begin
        reset        = 1'b1;
        rx_done_tick = 1'b0;
        rx_data      = 8'h00;
        rd_key       = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset state
        checkOutput("rst_empty", 16'(kb_empty0), 16'h1);
        checkOutput("rst_full", 16'(kb_full0), 16'h0);
        checkOutput("rst_ovf", 16'(overflow0), 16'h0);
        checkOutput("rst_perr", 16'(proto_err0), 16'h0);
        checkOutput("rst_head", head0(), 16'h000);

        // Make 1C is not queued, release 1C is queued once
        applyStimulus(8'h1C, 1'b0);
        checkOutput("t1_make_not_queued", 16'(kb_empty0), 16'h1);
        applyStimulus(8'hF0, 1'b0);
        checkOutput("t1_prefix_empty", 16'(kb_empty0), 16'h1);
        applyStimulus(8'h1C, 1'b0);
        checkOutput("t1_empty_fell", 16'(kb_empty0), 16'h0);
        checkOutput("t1_head", head0(), 16'h11C);
        popKey();
        checkOutput("t1_single_entry", 16'(kb_empty0), 16'h1);

        // Extended release, then ext flag must not persist
        applyStimulus(8'hE0, 1'b0);
        applyStimulus(8'hF0, 1'b0);
        applyStimulus(8'h75, 1'b0);
        checkOutput("t2_ext_brk", head0(), 16'h375);
        popKey();
        applyStimulus(8'h75, 1'b0);
        applyStimulus(8'hF0, 1'b0);
        applyStimulus(8'h75, 1'b0);
        checkOutput("t2_plain_brk", head0(), 16'h175);
        popKey();
        checkOutput("t2_empty", 16'(kb_empty0), 16'h1);

        // Six releases into a 4-deep FIFO with no pops
        applyStimulus(8'hF0, 1'b0); applyStimulus(8'h15, 1'b0);
        applyStimulus(8'hF0, 1'b0); applyStimulus(8'h1D, 1'b0);
        applyStimulus(8'hF0, 1'b0); applyStimulus(8'h24, 1'b0);
        checkOutput("t3_not_full_3", 16'(kb_full0), 16'h0);
        applyStimulus(8'hF0, 1'b0); applyStimulus(8'h2D, 1'b0);
        checkOutput("t3_full", 16'(kb_full0), 16'h1);
        checkOutput("t3_no_ovf_yet", 16'(overflow0), 16'h0);
        applyStimulus(8'hF0, 1'b0);
        applyStimulus(8'h2C, 1'b0);
        checkOutput("t3_ovf1", 16'(overflow0), 16'h1);
        idleCycle();
        checkOutput("t3_ovf1_pulse", 16'(overflow0), 16'h0);
        applyStimulus(8'hF0, 1'b0);
        applyStimulus(8'h35, 1'b0);
        checkOutput("t3_ovf2", 16'(overflow0), 16'h1);
        checkOutput("t3_head0", head0(), 16'h115);
        popKey();
        checkOutput("t3_head1", head0(), 16'h11D);
        popKey();
        checkOutput("t3_head2", head0(), 16'h124);
        popKey();
        checkOutput("t3_head3", head0(), 16'h12D);
        popKey();
        checkOutput("t3_drained", 16'(kb_empty0), 16'h1);

        // Full FIFO: push and pop in the same cycle
        applyStimulus(8'hF0, 1'b0); applyStimulus(8'h15, 1'b0);
        applyStimulus(8'hF0, 1'b0); applyStimulus(8'h1D, 1'b0);
        applyStimulus(8'hF0, 1'b0); applyStimulus(8'h24, 1'b0);
        applyStimulus(8'hF0, 1'b0); applyStimulus(8'h2D, 1'b0);
        checkOutput("t4_full_before", 16'(kb_full0), 16'h1);
        applyStimulus(8'hF0, 1'b0);
        applyStimulus(8'h2C, 1'b1);
        checkOutput("t4_no_ovf", 16'(overflow0), 16'h0);
        checkOutput("t4_still_full", 16'(kb_full0), 16'h1);
        checkOutput("t4_head_advanced", head0(), 16'h11D);
        popKey();
        popKey();
        popKey();
        checkOutput("t4_tail_entry", head0(), 16'h12C);
        popKey();
        checkOutput("t4_drained", 16'(kb_empty0), 16'h1);

        // Illegal prefix sequence, then recovery from IDLE
        applyStimulus(8'hF0, 1'b0);
        applyStimulus(8'hE0, 1'b0);
        checkOutput("t5_proto_err", 16'(proto_err0), 16'h1);
        checkOutput("t5_empty", 16'(kb_empty0), 16'h1);
        idleCycle();
        checkOutput("t5_proto_pulse", 16'(proto_err0), 16'h0);
        applyStimulus(8'hF0, 1'b0);
        applyStimulus(8'h29, 1'b0);
        checkOutput("t5_recovered", head0(), 16'h129);
        popKey();

        // Reset mid-sequence, pop while empty, then a make on the make-queuing instance
        applyStimulus(8'hF0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        popKey();
        checkOutput("t6_pop_empty0", 16'({kb_empty0, kb_full0, overflow0, proto_err0}), 16'h8);
        checkOutput("t6_pop_empty_head0", head0(), 16'h000);
        checkOutput("t6_pop_empty1", 16'({kb_empty1, kb_full1, overflow1, proto_err1}), 16'h8);
        checkOutput("t6_pop_empty_head1", head1(), 16'h000);
        applyStimulus(8'h1C, 1'b0);
        checkOutput("t6_make_queued", 16'(kb_empty1), 16'h0);
        checkOutput("t6_make_entry", head1(), 16'h01C);
        checkOutput("t6_release_only", 16'(kb_empty0), 16'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard time limit so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
